dctlb_assoc: RTL
================

// Module: dctlb_assoc
// PURPOSE
// - Parametrised L1 data TLB; next generation after the passthrough DCTLB. Sits beside the Dcache,
//   between the core ld/st ports and the L1 (fwd) and L2 TLB (req/ack/snoop/sack).
// - Fully associative ENTRIES-deep array, NPORTS lookup channels, one outstanding miss to the L2 TLB.
// - L2 snoops invalidate entries by hpaddr; the L1 is notified through cmd so it drops those lines.
// PARAMETERS
// NPORTS    2   lookup channels (port 0 = ld, port 1 = st; more ports allowed)
// ENTRIES   8   TLB entries (power of 2, >=2)
// VPN_W     27  virtual page number width (laddr[38:12])
// HPADDR_W  11  hpaddr width (L2TLB entry id)
// PPADDR_W  3   ppaddr width
// CORE_W    5   coreid width
// PORTS (name  dir  width  meaning)
// clk            in   1                 clock
// reset          in   1                 synchronous, active-high reset
// req_valid      in   NPORTS            per-port lookup valid
// req_retry      out  NPORTS            per-port back-pressure
// req_vpn        in   NPORTS*VPN_W      port p = bits [p*VPN_W +: VPN_W]
// req_coreid     in   NPORTS*CORE_W     port p coreid
// fwd_valid      out  NPORTS            translation to L1
// fwd_retry      in   NPORTS            L1 back-pressure
// fwd_coreid     out  NPORTS*CORE_W     echoed coreid
// fwd_hpaddr     out  NPORTS*HPADDR_W   translated hpaddr
// fwd_ppaddr     out  NPORTS*PPADDR_W   translated ppaddr
// fwd_fault      out  NPORTS*3          fault code stored with the entry
// l2req_valid    out  1                 miss request to L2 TLB
// l2req_retry    in   1                 L2 back-pressure
// l2req_vpn      out  VPN_W             missing vpn
// l2ack_valid    in   1                 fill from L2 TLB
// l2ack_retry    out  1                 always 0 (ack is accepted only in WAIT)
// l2ack_hpaddr   in   HPADDR_W          fill hpaddr
// l2ack_ppaddr   in   PPADDR_W          fill ppaddr
// l2ack_fault    in   3                 fill fault
// snoop_valid    in   1                 L2 displaced an entry
// snoop_retry    out  1                 snoop back-pressure
// snoop_hpaddr   in   HPADDR_W          displaced hpaddr
// sack_valid     out  1                 snoop ack to L2
// sack_retry     in   1                 L2 back-pressure
// sack_hpaddr    out  HPADDR_W          acked hpaddr
// cmd_valid      out  1                 invalidate notice to L1
// cmd_retry      in   1                 L1 back-pressure
// cmd_hpaddr     out  HPADDR_W          hpaddr to drop from L1
// BEHAVIOUR
// - Reset (sync, active-high): all entry valid bits clear, FSM=IDLE, rr_ptr=0. All *_valid outs are 0;
//   data outs are 0; req_retry=0 and snoop_retry=0 in the reset cycle. Reset mid-miss abandons the miss.
// - Hit (port p): req_valid && some entry valid with vpn==req_vpn, excluding entries matched by a snoop
//   accepted this cycle. fwd register p loads when (!fwd_valid[p] || !fwd_retry[p]). Latency is 1 cycle.
//   req_retry[p] = req_valid[p] && !(hit && fwd slot free). fwd holds stable while fwd_retry is high.
// - Miss: retry is held high. In IDLE, the lowest-index missing port is captured (vpn), then ->REQ.
// - FSM: IDLE -> REQ (l2req_valid=1, vpn stable) -> WAIT when !l2req_retry -> on l2ack_valid write
//   the victim {vpn,hpaddr,ppaddr,fault}, valid=1 -> IDLE. The core replays and hits the next cycle.
//   No other miss is captured until IDLE. Hits on other ports proceed during REQ and WAIT.
// - Victim: lowest-index invalid entry, else entry rr_ptr. rr_ptr increments mod ENTRIES per fill of a
//   valid entry. Fault entries are installed and forwarded like hits (the fault is carried).
// - Duplicate guard: if the missing vpn is already present at fill time, the existing entry is
//   overwritten and no second copy is made.
// - Snoop: accepted when snoop_valid && !sack_valid && !cmd_valid && !(WAIT && l2ack_valid). Otherwise
//   snoop_retry=1, so an ack on the same cycle wins and the snoop is retried one cycle later.
//   On accept, every valid entry with hpaddr==snoop_hpaddr is cleared in that cycle. The next cycle has
//   sack_valid=1; cmd_valid=1 only if >=1 entry matched. Each handshake drops independently on !retry.
// - Snoop hpaddr equal to the pending fill: the fill installs afterwards. L2 ordering guarantees this
//   is legal.
// - Same-cycle valid-clear (snoop) and fill to different entries both take effect.
// TESTING
// - Reset, then ld vpn 0x123 -> miss; l2req_vpn=0x123 one cycle later; ack {hp=0x7A,pp=3} -> replay
//   gives fwd_hpaddr=0x7A, fwd_ppaddr=3 one cycle after the hit.
// - Fill 9 distinct vpns with ENTRIES=8 -> the 9th replaces entry 0; vpn of entry 0 misses again,
//   entries 1..7 still hit.
// - Two entries share hp=0x55; snoop 0x55 -> both invalid; sack_valid=1 and cmd_hpaddr=0x55 the next
//   cycle. Snoop 0x66 (no match) -> sack only, no cmd.
// - Hold fwd_retry[0]=1 for 5 cycles with a ld hit pending -> fwd0 data stable; req_retry[0]=1 for a
//   second ld; port 1 st hits still forward.
// - Snoop and l2ack in the same WAIT cycle -> snoop_retry=1, fill installs, snoop accepted next cycle.
// - Assert reset while in WAIT -> valids 0, FSM IDLE; a late l2ack is ignored.

Source files
------------

// File: rtl/dctlb_assoc.sv
// Fully associative L1 data TLB: NPORTS lookup channels, one outstanding miss to the L2 TLB,
// snoop-driven invalidation by hpaddr with ack to L2 and drop notice to L1.
//
// state | meaning
// IDLE  | no miss outstanding; lowest-index missing port is captured
// REQ   | miss request presented to L2 TLB, waiting for !l2req_retry
// WAIT  | request accepted, waiting for l2ack fill
module dctlb_assoc #(
  parameter int NPORTS   = 2,
  parameter int ENTRIES  = 8,
  parameter int VPN_W    = 27,
  parameter int HPADDR_W = 11,
  parameter int PPADDR_W = 3,
  parameter int CORE_W   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            req_valid,
  output logic [NPORTS-1:0]            req_retry,
  input  logic [NPORTS*VPN_W-1:0]      req_vpn,
  input  logic [NPORTS*CORE_W-1:0]     req_coreid,
  output logic [NPORTS-1:0]            fwd_valid,
  input  logic [NPORTS-1:0]            fwd_retry,
  output logic [NPORTS*CORE_W-1:0]     fwd_coreid,
  output logic [NPORTS*HPADDR_W-1:0]   fwd_hpaddr,
  output logic [NPORTS*PPADDR_W-1:0]   fwd_ppaddr,
  output logic [NPORTS*3-1:0]          fwd_fault,
  output logic                         l2req_valid,
  input  logic                         l2req_retry,
  output logic [VPN_W-1:0]             l2req_vpn,
  input  logic                         l2ack_valid,
  output logic                         l2ack_retry,
  input  logic [HPADDR_W-1:0]          l2ack_hpaddr,
  input  logic [PPADDR_W-1:0]          l2ack_ppaddr,
  input  logic [2:0]                   l2ack_fault,
  input  logic                         snoop_valid,
  output logic                         snoop_retry,
  input  logic [HPADDR_W-1:0]          snoop_hpaddr,
  output logic                         sack_valid,
  input  logic                         sack_retry,
  output logic [HPADDR_W-1:0]          sack_hpaddr,
  output logic                         cmd_valid,
  input  logic                         cmd_retry,
  output logic [HPADDR_W-1:0]          cmd_hpaddr
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
  state_t state, state_nxt;

  logic [ENTRIES-1:0]  ent_valid;
  logic [VPN_W-1:0]    ent_vpn   [ENTRIES];
  logic [HPADDR_W-1:0] ent_hp    [ENTRIES];
  logic [PPADDR_W-1:0] ent_pp    [ENTRIES];
  logic [2:0]          ent_fault [ENTRIES];

  logic [VPN_W-1:0] miss_vpn;
  logic [IDX_W-1:0] rr_ptr;

  logic [NPORTS-1:0][VPN_W-1:0]    req_vpn_a;
  logic [NPORTS-1:0][CORE_W-1:0]   req_core_a;
  logic [NPORTS-1:0][CORE_W-1:0]   fwd_core_q;
  logic [NPORTS-1:0][HPADDR_W-1:0] fwd_hp_q;
  logic [NPORTS-1:0][PPADDR_W-1:0] fwd_pp_q;
  logic [NPORTS-1:0][2:0]          fwd_fault_q;

  assign req_vpn_a  = req_vpn;
  assign req_core_a = req_coreid;
  assign fwd_coreid = fwd_core_q;
  assign fwd_hpaddr = fwd_hp_q;
  assign fwd_ppaddr = fwd_pp_q;
  assign fwd_fault  = fwd_fault_q;
  assign l2req_vpn  = miss_vpn;
  assign l2ack_retry = 1'b0;

  logic               snoop_acc;
  logic [ENTRIES-1:0] snoop_match;
  logic [ENTRIES-1:0] snoop_clr;

  // An ack in WAIT takes priority; the snoop is retried and lands after the fill.
  always_comb begin
    snoop_acc   = !reset && snoop_valid && !sack_valid && !cmd_valid &&
                  !(state == ST_WAIT && l2ack_valid);
    snoop_retry = !reset && snoop_valid && !snoop_acc;
    for (int e = 0; e < ENTRIES; e++) begin
      snoop_match[e] = ent_valid[e] && (ent_hp[e] == snoop_hpaddr);
    end
    snoop_clr = snoop_acc ? snoop_match : '0;
  end

  logic [NPORTS-1:0]            hit;
  logic [NPORTS-1:0][IDX_W-1:0] hit_idx;
  logic [NPORTS-1:0]            fwd_load;
  logic                         miss_any;
  logic [VPN_W-1:0]             miss_sel_vpn;

  always_comb begin
    hit          = '0;
    hit_idx      = '0;
    fwd_load     = '0;
    req_retry    = '0;
    miss_any     = 1'b0;
    miss_sel_vpn = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int e = ENTRIES-1; e >= 0; e--) begin
        if (ent_valid[e] && !snoop_clr[e] && (ent_vpn[e] == req_vpn_a[p])) begin
          hit[p]     = 1'b1;
          hit_idx[p] = IDX_W'(e);
        end
      end
      fwd_load[p]  = !reset && req_valid[p] && hit[p] && (!fwd_valid[p] || !fwd_retry[p]);
      req_retry[p] = !reset && req_valid[p] && !fwd_load[p];
    end
    for (int p = NPORTS-1; p >= 0; p--) begin
      if (req_valid[p] && !hit[p]) begin
        miss_any     = 1'b1;
        miss_sel_vpn = req_vpn_a[p];
      end
    end
  end

  logic             fill_en;
  logic             dup_hit;
  logic [IDX_W-1:0] dup_idx;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim;
  logic             rr_adv;

  // Refilling a vpn already present overwrites it so the array never holds two copies.
  always_comb begin
    dup_hit  = 1'b0;
    dup_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int e = ENTRIES-1; e >= 0; e--) begin
      if (ent_valid[e] && (ent_vpn[e] == miss_vpn)) begin
        dup_hit = 1'b1;
        dup_idx = IDX_W'(e);
      end
      if (!ent_valid[e]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(e);
      end
    end
    victim = dup_hit ? dup_idx : (free_any ? free_idx : rr_ptr);
    rr_adv = fill_en && !dup_hit && !free_any;
  end

  always_comb begin
    state_nxt   = state;
    l2req_valid = 1'b0;
    fill_en     = 1'b0;
    case (state)
      ST_IDLE: if (miss_any) state_nxt = ST_REQ;
      ST_REQ: begin
        l2req_valid = !reset;
        if (!l2req_retry) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (l2ack_valid) begin
          fill_en   = !reset;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ent_valid   <= '0;
      rr_ptr      <= '0;
      miss_vpn    <= '0;
      sack_valid  <= 1'b0;
      sack_hpaddr <= '0;
      cmd_valid   <= 1'b0;
      cmd_hpaddr  <= '0;
      fwd_valid   <= '0;
      fwd_core_q  <= '0;
      fwd_hp_q    <= '0;
      fwd_pp_q    <= '0;
      fwd_fault_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && miss_any) miss_vpn <= miss_sel_vpn;

      ent_valid <= ent_valid & ~snoop_clr;
      if (fill_en) ent_valid[victim] <= 1'b1;
      if (rr_adv) rr_ptr <= rr_ptr + 1'b1;

      if (snoop_acc) begin
        sack_valid  <= 1'b1;
        sack_hpaddr <= snoop_hpaddr;
        cmd_valid   <= |snoop_match;
        cmd_hpaddr  <= snoop_hpaddr;
      end else begin
        if (sack_valid && !sack_retry) sack_valid <= 1'b0;
        if (cmd_valid && !cmd_retry) cmd_valid <= 1'b0;
      end

      for (int p = 0; p < NPORTS; p++) begin
        if (fwd_load[p]) begin
          fwd_valid[p]   <= 1'b1;
          fwd_core_q[p]  <= req_core_a[p];
          fwd_hp_q[p]    <= ent_hp[hit_idx[p]];
          fwd_pp_q[p]    <= ent_pp[hit_idx[p]];
          fwd_fault_q[p] <= ent_fault[hit_idx[p]];
        end else if (fwd_valid[p] && !fwd_retry[p]) begin
          fwd_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      ent_vpn[victim]   <= miss_vpn;
      ent_hp[victim]    <= l2ack_hpaddr;
      ent_pp[victim]    <= l2ack_ppaddr;
      ent_fault[victim] <= l2ack_fault;
    end
  end

endmodule
